// File: rtl/wrt_ingress_ctrl.sv
// -----------------------------------------------------------------------------
// wrt_ingress_ctrl
// Write-clock-domain front end of the async FIFO. Producer words arrive on a
// valid/ready handshake and land in a 2-entry skid buffer. The head of that
// buffer is offered to the FIFO (wrt_en/wrt_data) whenever the registered
// full flag is low. Because in_ready is a register, it never depends
// combinationally on full. The block also derives a write-side fill level and
// almost_full from the gray pointers, and counts cycles stalled on full.
//
// Ports:
//   wrt_clk      in   write-domain clock
//   wrt_rst_n    in   asynchronous active-low reset
//   in_valid     in   producer data valid
//   in_data      in   producer data [DW]
//   in_ready     out  block can accept a word this cycle (registered)
//   wrt_en       out  write request to pointer/full block
//   wrt_data     out  data to FIFO memory write port [DW]
//   full         in   registered FIFO full flag
//   wrt_ptr      in   write gray pointer [ADDR_W+1]
//   wq2_rd_ptr   in   read gray pointer synchronized into wrt_clk [ADDR_W+1]
//   fill_level   out  occupancy seen from the write side (registered)
//   almost_full  out  fill_level >= AF_THRESH (registered)
//   stall_cnt    out  saturating count of cycles stalled on full [16]
//   clr_stall    in   synchronous clear of stall_cnt
// -----------------------------------------------------------------------------
module wrt_ingress_ctrl #(
    parameter int DW        = 8,
    parameter int ADDR_W    = 6,
    parameter int AF_THRESH = 56
) (
    input  logic              wrt_clk,
    input  logic              wrt_rst_n,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              in_ready,
    output logic              wrt_en,
    output logic [DW-1:0]     wrt_data,
    input  logic              full,
    input  logic [ADDR_W:0]   wrt_ptr,
    input  logic [ADDR_W:0]   wq2_rd_ptr,
    output logic [ADDR_W:0]   fill_level,
    output logic              almost_full,
    output logic [15:0]       stall_cnt,
    input  logic              clr_stall
);

    localparam int PW = ADDR_W + 1;

    // Threshold held at pointer width so the compare is width-matched.
    localparam logic [31:0]   AF_THRESH_W = AF_THRESH;
    localparam logic [PW-1:0] AF_LIM      = AF_THRESH_W[PW-1:0];

    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Skid buffer: entry 0 is always the head, entry 1 the tail when two are held.
    logic [DW-1:0] ent0_q, ent0_d;
    logic [DW-1:0] ent1_q, ent1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          in_ready_q;
    logic          push_s;
    logic          pop_s;

    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] diff_s;
    logic [PW-1:0] fill_q;
    logic          af_q;
    logic [15:0]   stall_q;

    // full is a register downstream, so gating wrt_en with it forms no loop.
    assign pop_s    = (cnt_q != 2'd0) & ~full;
    assign push_s   = in_valid & in_ready_q;

    assign wrt_en      = pop_s;
    assign wrt_data    = (cnt_q != 2'd0) ? ent0_q : {DW{1'b0}};
    assign in_ready    = in_ready_q;
    assign fill_level  = fill_q;
    assign almost_full = af_q;
    assign stall_cnt   = stall_q;

    // Next-state of the skid buffer from the push/pop pair.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = in_data;
                end else begin
                    ent1_d = in_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                ent1_d = {DW{1'b0}};
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the incoming word lands behind whatever
                // remains after the head leaves.
                if (cnt_q == 2'd1) begin
                    ent0_d = in_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_data;
                end
            end
            default: begin
                ent0_d = ent0_q;
                ent1_d = ent1_q;
                cnt_d  = cnt_q;
            end
        endcase
    end

    // Skid buffer storage, occupancy and the registered ready flag.
    always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
        if (!wrt_rst_n) begin
            ent0_q     <= {DW{1'b0}};
            ent1_q     <= {DW{1'b0}};
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != 2'd2);
        end
    end

    // Modular pointer difference handles wrap of the extra pointer bit.
    assign wbin_s = gray2bin(wrt_ptr);
    assign rbin_s = gray2bin(wq2_rd_ptr);
    assign diff_s = wbin_s - rbin_s;

    // Fill level and almost_full registered together from the same diff.
    always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
        if (!wrt_rst_n) begin
            fill_q <= {PW{1'b0}};
            af_q   <= 1'b0;
        end else begin
            fill_q <= diff_s;
            af_q   <= (diff_s >= AF_LIM);
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
        if (!wrt_rst_n) begin
            stall_q <= 16'h0000;
        end else if (clr_stall) begin
            stall_q <= 16'h0000;
        end else if ((cnt_q != 2'd0) && full && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end else begin
            stall_q <= stall_q;
        end
    end

endmodule

// File: tb/tb_wrt_ingress_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for wrt_ingress_ctrl: directed handshake sequences,
// a table of pointer pairs for fill_level/almost_full, stall saturation and
// clear, and asynchronous reset with a full skid buffer.
// -----------------------------------------------------------------------------
module tb_wrt_ingress_ctrl;

    logic        wrt_clk;
    logic        wrt_rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wrt_en;
    logic [7:0]  wrt_data;
    logic        full;
    logic [6:0]  wrt_ptr;
    logic [6:0]  wq2_rd_ptr;
    logic [6:0]  fill_level;
    logic        almost_full;
    logic [15:0] stall_cnt;
    logic        clr_stall;

    int n_total;
    int n_pass;

    typedef struct {
        logic [6:0] wbin;
        logic [6:0] rbin;
        logic [6:0] fill;
        logic       af;
    } fvec_t;

    fvec_t fv[8];

    wrt_ingress_ctrl #(.DW(8), .ADDR_W(6), .AF_THRESH(56)) dut (
        .wrt_clk     (wrt_clk),
        .wrt_rst_n   (wrt_rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wrt_en      (wrt_en),
        .wrt_data    (wrt_data),
        .full        (full),
        .wrt_ptr     (wrt_ptr),
        .wq2_rd_ptr  (wq2_rd_ptr),
        .fill_level  (fill_level),
        .almost_full (almost_full),
        .stall_cnt   (stall_cnt),
        .clr_stall   (clr_stall)
    );

    initial wrt_clk = 1'b0;
    always #5 wrt_clk = ~wrt_clk;

    function automatic logic [6:0] to_gray(input logic [6:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wrt_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        wrt_rst_n  = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        full       = 1'b0;
        wrt_ptr    = 7'd0;
        wq2_rd_ptr = 7'd0;
        clr_stall  = 1'b0;

        fv[0] = '{7'd3,   7'd125, 7'd6,  1'b0};
        fv[1] = '{7'd64,  7'd0,   7'd64, 1'b1};
        fv[2] = '{7'd55,  7'd0,   7'd55, 1'b0};
        fv[3] = '{7'd56,  7'd0,   7'd56, 1'b1};
        fv[4] = '{7'd0,   7'd0,   7'd0,  1'b0};
        fv[5] = '{7'd100, 7'd40,  7'd60, 1'b1};
        fv[6] = '{7'd10,  7'd9,   7'd1,  1'b0};
        fv[7] = '{7'd2,   7'd66,  7'd64, 1'b1};

        // 1. reset and release
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wrt_en", 32'(wrt_en), 32'd0);
        check("rst_wrt_data", 32'(wrt_data), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        wrt_rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre", 32'(in_ready), 32'd0);
        tick();
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_wrt_en", 32'(wrt_en), 32'd0);

        // 2. streaming with full low: one-word pass-through every cycle
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            check("stream_wrt_en", 32'(wrt_en), 32'd1);
            check("stream_wrt_data", 32'(wrt_data), 32'(i));
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_en", 32'(wrt_en), 32'd0);
        check("stream_drain_data", 32'(wrt_data), 32'd0);

        // 3. back-pressure on full
        full     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA1;
        tick();
        check("bp_ready1", 32'(in_ready), 32'd1);
        check("bp_en1", 32'(wrt_en), 32'd0);
        check("bp_stall0", 32'(stall_cnt), 32'd0);
        in_data = 8'hA2;
        tick();
        check("bp_ready2", 32'(in_ready), 32'd0);
        check("bp_en2", 32'(wrt_en), 32'd0);
        check("bp_head", 32'(wrt_data), 32'hA1);
        check("bp_stall1", 32'(stall_cnt), 32'd1);
        in_data = 8'hA3;
        tick();
        check("bp_stall2", 32'(stall_cnt), 32'd2);
        check("bp_ready3", 32'(in_ready), 32'd0);
        tick();
        check("bp_stall3", 32'(stall_cnt), 32'd3);
        full = 1'b0;
        #1;
        check("rel_en_a1", 32'(wrt_en), 32'd1);
        check("rel_data_a1", 32'(wrt_data), 32'hA1);
        tick();
        check("rel_data_a2", 32'(wrt_data), 32'hA2);
        check("rel_en_a2", 32'(wrt_en), 32'd1);
        check("rel_ready", 32'(in_ready), 32'd1);
        check("rel_stall_hold", 32'(stall_cnt), 32'd3);
        tick();
        check("rel_data_a3", 32'(wrt_data), 32'hA3);
        check("rel_en_a3", 32'(wrt_en), 32'd1);
        in_valid = 1'b0;
        tick();
        check("rel_drained", 32'(wrt_en), 32'd0);
        clr_stall = 1'b1;
        tick();
        clr_stall = 1'b0;
        check("clr_stall", 32'(stall_cnt), 32'd0);

        // 4. fill level table (gray pointers, 1-cycle latency)
        for (int k = 0; k < 8; k++) begin
            wrt_ptr    = to_gray(fv[k].wbin);
            wq2_rd_ptr = to_gray(fv[k].rbin);
            tick();
            check($sformatf("fill_%0d", k), 32'(fill_level), 32'(fv[k].fill));
            check($sformatf("af_%0d", k), 32'(almost_full), 32'(fv[k].af));
        end
        wrt_ptr    = 7'd0;
        wq2_rd_ptr = 7'd0;

        // 5. stall saturation and clear priority
        full     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        check("sat_start", 32'(stall_cnt), 32'd0);
        repeat (65534) tick();
        check("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        tick();
        check("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        tick();
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);
        clr_stall = 1'b1;
        tick();
        clr_stall = 1'b0;
        check("sat_clr", 32'(stall_cnt), 32'd0);
        tick();
        check("sat_resume1", 32'(stall_cnt), 32'd1);
        tick();
        check("sat_resume2", 32'(stall_cnt), 32'd2);

        // 6. async reset with two words buffered and full high
        in_valid = 1'b1;
        in_data  = 8'h66;
        tick();
        in_valid = 1'b0;
        check("r6_ready_low", 32'(in_ready), 32'd0);
        check("r6_head", 32'(wrt_data), 32'h55);
        wrt_rst_n = 1'b0;
        #1;
        check("r6_ready", 32'(in_ready), 32'd0);
        check("r6_en", 32'(wrt_en), 32'd0);
        check("r6_data", 32'(wrt_data), 32'd0);
        check("r6_stall", 32'(stall_cnt), 32'd0);
        full = 1'b0;
        #1;
        check("r6_en_nofull", 32'(wrt_en), 32'd0);
        wrt_rst_n = 1'b1;
        tick();
        check("r6_rel_ready", 32'(in_ready), 32'd1);
        for (int j = 0; j < 4; j++) begin
            check("r6_no_old_en", 32'(wrt_en), 32'd0);
            check("r6_no_old_data", 32'(wrt_data), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
